// File: rtl/writeback_arbiter_pkg.sv
// ============================================================================
// Module   : writeback_arbiter_pkg
// Brief    : Shared types and constants for the writeback arbiter slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package writeback_arbiter_pkg;

    localparam int REGISTER_ADDRESS_BITS = 3;
    localparam int REGISTER_DATA_BITS    = 8;
    localparam int WB_FIFO_DEPTH         = 2;

    typedef struct packed {
        logic [REGISTER_ADDRESS_BITS-1:0] addr;
        logic [REGISTER_DATA_BITS-1:0]    data;
    } wb_entry_t;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_MEM = 1'b1
    } wb_src_t;

endpackage

`default_nettype wire

// File: rtl/writeback_arbiter_if.sv
// ============================================================================
// Module   : writeback_arbiter_if
// Brief    : Producer handshakes, register-file write port and hazard mask.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface writeback_arbiter_if #(
    parameter int ADDR_BITS = 3,
    parameter int DATA_BITS = 8
);
    localparam int NREGS = 2 ** ADDR_BITS;

    logic                 alu_valid;
    logic                 alu_ready;
    logic [ADDR_BITS-1:0] alu_addr;
    logic [DATA_BITS-1:0] alu_data;
    logic                 mem_valid;
    logic                 mem_ready;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [DATA_BITS-1:0] mem_data;
    logic [ADDR_BITS-1:0] wr_addr;
    logic                 wr_enable;
    logic [DATA_BITS-1:0] wr_data;
    logic [NREGS-1:0]     pending_mask;
    logic                 idle;

    modport slave (
        input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
        output alu_ready, mem_ready, wr_addr, wr_enable, wr_data, pending_mask, idle
    );

    modport master (
        output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
        input  alu_ready, mem_ready, wr_addr, wr_enable, wr_data, pending_mask, idle
    );
endinterface

`default_nettype wire

// File: rtl/writeback_arbiter_fifo.sv
// ============================================================================
// Module   : wb_fifo
// Brief    : Synchronous FIFO of wb_entry_t exposing per-slot valid/addr.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_fifo
    import writeback_arbiter_pkg::*;
#(
    parameter int DEPTH = WB_FIFO_DEPTH
) (
    input  wire logic                                        clk,
    input  wire logic                                        reset,
    input  wire logic                                        i_push,
    input  wire wb_entry_t                                   i_entry,
    input  wire logic                                        i_pop,
    output logic                                             o_full,
    output logic                                             o_empty,
    output wb_entry_t                                        o_head,
    output logic [DEPTH-1:0]                                 o_valid,
    output logic [DEPTH-1:0][REGISTER_ADDRESS_BITS-1:0]      o_addr
);
    localparam int PW = $clog2(DEPTH);

    wb_entry_t     r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == (PW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rptr];
    // A full FIFO refuses pushes even when it pops on the same edge.
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_entry;
    end

    // Slot i is live when its distance from the read pointer is below the count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic [PW-1:0] w_off;
        assign w_off      = PW'(i) - r_rptr;
        assign o_valid[i] = ({1'b0, w_off} < r_count);
        assign o_addr[i]  = r_mem[i].addr;
    end

endmodule

`default_nettype wire

// File: rtl/writeback_arbiter.sv
// ============================================================================
// Module   : writeback_arbiter
// Brief    : Two-source round-robin writeback into a single register-file port.
//            Optional macro WRITEBACK_EMPTY_BYPASS_EN: empty-FIFO bypass.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int ADDR_BITS  = REGISTER_ADDRESS_BITS,
    parameter int DATA_BITS  = REGISTER_DATA_BITS,
    parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
    input  wire logic              clk,
    input  wire logic              reset,
    writeback_arbiter_if.slave     bus
);
    localparam int NREGS = 2 ** ADDR_BITS;

    wb_entry_t                                        w_alu_in, w_mem_in, w_alu_head, w_mem_head, w_sel;
    logic                                             w_alu_full, w_alu_empty, w_mem_full, w_mem_empty;
    logic [FIFO_DEPTH-1:0]                            w_alu_vld, w_mem_vld;
    logic [FIFO_DEPTH-1:0][REGISTER_ADDRESS_BITS-1:0] w_alu_vaddr, w_mem_vaddr;
    logic                                             w_alu_acc, w_mem_acc, w_alu_avail, w_mem_avail;
    logic                                             w_alu_push, w_mem_push, w_alu_pop, w_mem_pop;
    logic                                             w_alu_byp, w_mem_byp;
    logic                                             w_grant_valid;
    wb_src_t                                          w_grant, r_rr, w_rr_next;
    logic                                             r_wr_en;
    logic [ADDR_BITS-1:0]                             r_wr_addr;
    logic [DATA_BITS-1:0]                             r_wr_data;
    logic [NREGS-1:0]                                 w_pending;

    assign w_alu_in  = '{addr: bus.alu_addr, data: bus.alu_data};
    assign w_mem_in  = '{addr: bus.mem_addr, data: bus.mem_data};
    assign w_alu_acc = bus.alu_valid && !w_alu_full;
    assign w_mem_acc = bus.mem_valid && !w_mem_full;

`ifdef WRITEBACK_EMPTY_BYPASS_EN
    // An incoming result on an empty source acts as that source's head.
    assign w_alu_avail = !w_alu_empty || w_alu_acc;
    assign w_mem_avail = !w_mem_empty || w_mem_acc;
`else
    assign w_alu_avail = !w_alu_empty;
    assign w_mem_avail = !w_mem_empty;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_rr <= WB_SRC_ALU;
        else        r_rr <= w_rr_next;
    end

    always_comb begin
        w_rr_next     = r_rr;
        w_grant_valid = 1'b0;
        w_grant       = WB_SRC_ALU;
        if (w_alu_avail && w_mem_avail) begin
            w_grant_valid = 1'b1;
            w_grant       = r_rr;
            w_rr_next     = (r_rr == WB_SRC_ALU) ? WB_SRC_MEM : WB_SRC_ALU;
        end else if (w_alu_avail) begin
            w_grant_valid = 1'b1;
            w_grant       = WB_SRC_ALU;
        end else if (w_mem_avail) begin
            w_grant_valid = 1'b1;
            w_grant       = WB_SRC_MEM;
        end
    end

    assign w_alu_pop  = w_grant_valid && (w_grant == WB_SRC_ALU) && !w_alu_empty;
    assign w_mem_pop  = w_grant_valid && (w_grant == WB_SRC_MEM) && !w_mem_empty;
    assign w_alu_byp  = w_grant_valid && (w_grant == WB_SRC_ALU) && w_alu_empty;
    assign w_mem_byp  = w_grant_valid && (w_grant == WB_SRC_MEM) && w_mem_empty;
    assign w_alu_push = w_alu_acc && !w_alu_byp;
    assign w_mem_push = w_mem_acc && !w_mem_byp;

    always_comb begin
        w_sel = w_alu_head;
        if (w_grant == WB_SRC_ALU) w_sel = w_alu_empty ? w_alu_in : w_alu_head;
        else                       w_sel = w_mem_empty ? w_mem_in : w_mem_head;
    end

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_alu_push),
        .i_entry (w_alu_in),
        .i_pop   (w_alu_pop),
        .o_full  (w_alu_full),
        .o_empty (w_alu_empty),
        .o_head  (w_alu_head),
        .o_valid (w_alu_vld),
        .o_addr  (w_alu_vaddr)
    );

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_mem_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_mem_push),
        .i_entry (w_mem_in),
        .i_pop   (w_mem_pop),
        .o_full  (w_mem_full),
        .o_empty (w_mem_empty),
        .o_head  (w_mem_head),
        .o_valid (w_mem_vld),
        .o_addr  (w_mem_vaddr)
    );

    // Address/data hold their last value on idle cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_grant_valid;
            if (w_grant_valid) begin
                r_wr_addr <= w_sel.addr;
                r_wr_data <= w_sel.data;
            end
        end
    end

    always_comb begin
        w_pending = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (w_alu_vld[i]) w_pending[w_alu_vaddr[i]] = 1'b1;
            if (w_mem_vld[i]) w_pending[w_mem_vaddr[i]] = 1'b1;
        end
        if (r_wr_en) w_pending[r_wr_addr] = 1'b1;
    end

    assign bus.alu_ready    = !w_alu_full;
    assign bus.mem_ready    = !w_mem_full;
    assign bus.wr_enable    = r_wr_en;
    assign bus.wr_addr      = r_wr_addr;
    assign bus.wr_data      = r_wr_data;
    assign bus.pending_mask = w_pending;
    assign bus.idle         = w_alu_empty && w_mem_empty && !r_wr_en;

endmodule

`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
// ============================================================================
// Module   : tb_writeback_arbiter
// Brief    : Randomized bench with a queue-based reference model of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_writeback_arbiter;
    localparam int DEPTH = 2;

    typedef struct {
        logic [2:0] a;
        logic [7:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   chk_en = 1'b0;

    writeback_arbiter_if #(.ADDR_BITS(3), .DATA_BITS(8)) bus();

    writeback_arbiter #(.ADDR_BITS(3), .DATA_BITS(8), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: two queues, a round-robin flag and the output register.
    ent_t       aq[$];
    ent_t       mq[$];
    bit         m_rr;
    bit         m_en;
    logic [2:0] m_addr;
    logic [7:0] m_data;
    bit         a_took, m_took;

    always @(posedge clk or negedge reset) begin : model
        bit   a_acc, m_acc, a_av, m_av, a_byp, m_byp;
        int   g;
        ent_t e, ai, mi;
        if (!reset) begin
            aq.delete(); mq.delete();
            m_rr = 0; m_en = 0; m_addr = '0; m_data = '0;
            a_took = 0; m_took = 0;
        end else begin
            a_acc = bus.alu_valid && (aq.size() < DEPTH);
            m_acc = bus.mem_valid && (mq.size() < DEPTH);
            ai = '{bus.alu_addr, bus.alu_data};
            mi = '{bus.mem_addr, bus.mem_data};
`ifdef WRITEBACK_EMPTY_BYPASS_EN
            a_av = (aq.size() > 0) || a_acc;
            m_av = (mq.size() > 0) || m_acc;
`else
            a_av = (aq.size() > 0);
            m_av = (mq.size() > 0);
`endif
            g = 0;
            if (a_av && m_av) begin g = m_rr ? 2 : 1; m_rr = !m_rr; end
            else if (a_av) g = 1;
            else if (m_av) g = 2;
            a_byp = 0; m_byp = 0;
            e = ai;
            if (g == 1) begin
                if (aq.size() > 0) e = aq.pop_front();
                else begin e = ai; a_byp = 1; end
            end else if (g == 2) begin
                if (mq.size() > 0) e = mq.pop_front();
                else begin e = mi; m_byp = 1; end
            end
            if (a_acc && !a_byp) aq.push_back(ai);
            if (m_acc && !m_byp) mq.push_back(mi);
            m_en = (g != 0);
            if (g != 0) begin m_addr = e.a; m_data = e.d; end
            a_took = a_acc; m_took = m_acc;
        end
    end

    function automatic logic [7:0] exp_mask();
        logic [7:0] m = '0;
        foreach (aq[i]) m[aq[i].a] = 1'b1;
        foreach (mq[i]) m[mq[i].a] = 1'b1;
        if (m_en) m[m_addr] = 1'b1;
        return m;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin : compare
        if (reset && chk_en) begin
            chk("wr_enable", 32'(bus.wr_enable), 32'(m_en));
            chk("wr_addr",   32'(bus.wr_addr),   32'(m_addr));
            chk("wr_data",   32'(bus.wr_data),   32'(m_data));
            chk("alu_ready", 32'(bus.alu_ready), 32'(aq.size() < DEPTH));
            chk("mem_ready", 32'(bus.mem_ready), 32'(mq.size() < DEPTH));
            chk("pending",   32'(bus.pending_mask), 32'(exp_mask()));
            chk("idle",      32'(bus.idle), 32'(aq.size() == 0 && mq.size() == 0 && !m_en));
        end
    end

    task automatic drive_random();
        if (!(bus.alu_valid && !a_took)) begin
            bus.alu_valid = 1'($urandom_range(0, 1));
            bus.alu_addr  = 3'($urandom);
            bus.alu_data  = 8'($urandom);
        end
        if (!(bus.mem_valid && !m_took)) begin
            bus.mem_valid = 1'($urandom_range(0, 1));
            bus.mem_addr  = 3'($urandom);
            bus.mem_data  = 8'($urandom);
        end
    endtask

    ent_t writes[$];
    logic [7:0] ac, mc;

    initial begin
        bus.alu_valid = 0; bus.alu_addr = '0; bus.alu_data = '0;
        bus.mem_valid = 0; bus.mem_addr = '0; bus.mem_data = '0;

        repeat (3) @(negedge clk);
        chk("rst_wr_enable", 32'(bus.wr_enable), 0);
        chk("rst_pending",   32'(bus.pending_mask), 0);
        chk("rst_idle",      32'(bus.idle), 1);
        reset = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rel_alu_ready", 32'(bus.alu_ready), 1);
        chk("rel_mem_ready", 32'(bus.mem_ready), 1);
        chk("rel_pending",   32'(bus.pending_mask), 0);

        // Single ALU push, addr 3 data 0x5A.
        bus.alu_valid = 1; bus.alu_addr = 3'd3; bus.alu_data = 8'h5A;
        @(negedge clk);
        bus.alu_valid = 0;
        chk("push_mask_E", 32'(bus.pending_mask), 32'h08);
`ifdef WRITEBACK_EMPTY_BYPASS_EN
        chk("push_en_E",   32'(bus.wr_enable), 1);
        chk("push_addr_E", 32'(bus.wr_addr), 3);
        chk("push_data_E", 32'(bus.wr_data), 32'h5A);
        @(negedge clk);
        chk("push_en_E1",  32'(bus.wr_enable), 0);
        chk("push_mask_E1", 32'(bus.pending_mask), 0);
`else
        chk("push_en_E",   32'(bus.wr_enable), 0);
        @(negedge clk);
        chk("push_en_E1",   32'(bus.wr_enable), 1);
        chk("push_addr_E1", 32'(bus.wr_addr), 3);
        chk("push_data_E1", 32'(bus.wr_data), 32'h5A);
        chk("push_mask_E1", 32'(bus.pending_mask), 32'h08);
`endif
        @(negedge clk);
        chk("push_mask_E2", 32'(bus.pending_mask), 0);
        chk("push_idle_E2", 32'(bus.idle), 1);

        // Both sources streaming: ALU addr 1 from 0x10, mem addr 2 from 0x80.
        writes.delete();
        ac = 8'h10; mc = 8'h80;
        bus.alu_valid = 1; bus.alu_addr = 3'd1; bus.alu_data = ac;
        bus.mem_valid = 1; bus.mem_addr = 3'd2; bus.mem_data = mc;
        for (int i = 0; i < 200 && writes.size() < 20; i++) begin
            @(negedge clk);
            if (bus.wr_enable) writes.push_back('{bus.wr_addr, bus.wr_data});
            if (a_took) ac = ac + 8'd1;
            if (m_took) mc = mc + 8'd1;
            bus.alu_data = ac;
            bus.mem_data = mc;
        end
        bus.alu_valid = 0; bus.mem_valid = 0;
        chk("stream_count", 32'(writes.size() >= 20), 1);
        foreach (writes[i]) begin
            if (i < 20) begin
                chk("stream_addr", 32'(writes[i].a), (i % 2 == 0) ? 1 : 2);
                chk("stream_data", 32'(writes[i].d), (i % 2 == 0) ? 32'h10 + i / 2 : 32'h80 + i / 2);
            end
        end
        repeat (6) @(negedge clk);
        chk("stream_idle", 32'(bus.idle), 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            drive_random();
        end

        // Fill both FIFOs, then reset asynchronously mid-stream.
        bus.alu_valid = 1; bus.mem_valid = 1;
        repeat (4) @(negedge clk);
        chk("pre_reset_occupancy", 32'((aq.size() + mq.size() + (m_en ? 1 : 0)) >= 3), 1);
        #2 reset = 1'b0;
        #1;
        chk("midrst_wr_enable", 32'(bus.wr_enable), 0);
        chk("midrst_pending",   32'(bus.pending_mask), 0);
        bus.alu_valid = 0; bus.mem_valid = 0;
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_wr_enable", 32'(bus.wr_enable), 0);
        chk("post_rst_idle",      32'(bus.idle), 1);

        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            drive_random();
        end
        bus.alu_valid = 0; bus.mem_valid = 0;
        repeat (8) @(negedge clk);
        chk("final_idle", 32'(bus.idle), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Writeback stage directly upstream of the register file's single write port (wr_addr/wr_enable/wr_data).
- Accepts results from two producers, the ALU and the load unit, through valid/ready handshakes, and buffers each in its own FIFO.
- Arbitrates round-robin between the two FIFOs and drives one registered write per cycle.
- Exports a per-register pending-write mask so the decoder can stall on read-after-write hazards.

Parameters:
ADDR_BITS, REGISTER_ADDRESS_BITS (3), register address width; register count NREGS = 2**ADDR_BITS
DATA_BITS, REGISTER_DATA_BITS, register data width
FIFO_DEPTH, 2, entries per source FIFO; power of two, >= 2

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
alu_valid  input  1  ALU result valid
alu_ready  output  1  ALU FIFO can accept
alu_addr  input  ADDR_BITS  ALU destination register
alu_data  input  DATA_BITS  ALU result
mem_valid  input  1  load result valid
mem_ready  output  1  load FIFO can accept
mem_addr  input  ADDR_BITS  load destination register
mem_data  input  DATA_BITS  loaded value
wr_addr  output  ADDR_BITS  register file write address
wr_enable  output  1  register file write enable
wr_data  output  DATA_BITS  register file write data
pending_mask  output  NREGS  bit r = a write to register r is in flight
idle  output  1  both FIFOs empty and wr_enable low

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFOs flushed; wr_enable=0, wr_addr=0, wr_data=0.
  - pending_mask=0; idle=1.
  - Round-robin pointer favours ALU.
  - Any accepted-but-unwritten result is discarded, including one in the output register.
- Accept rule: a transfer occurs at a rising edge where x_valid && x_ready.
  - x_ready = !full(x), computed combinationally from occupancy only.
  - A full FIFO does not accept even if it pops in the same cycle.
  - x_valid with x_ready=0 holds; producers keep addr/data stable.
- Per-FIFO simultaneous push and pop when neither empty nor full: both happen and the count is unchanged.
- Pop on empty never occurs.
- Pointers wrap modulo FIFO_DEPTH; occupancy counter is $clog2(FIFO_DEPTH)+1 bits.
- Arbitration, each cycle, from the FIFO head states:
  - Neither FIFO non-empty: nothing popped.
  - One non-empty: pop it.
  - Both non-empty: pop the one the pointer favours, then flip the pointer to the other source.
  - The pointer changes only on a contested grant.
- Output register, loaded every edge:
  - Popped entry: wr_enable=1 with its addr/data.
  - No pop: wr_enable=0; wr_addr/wr_data keep their previous values.
- Latency: result accepted at edge E appears on the write port in the cycle after edge E+1. The register file captures it at E+2.
- Ordering:
  - Per-source order is preserved.
  - Cross-source order to the same register is not guaranteed; the decoder prevents it via pending_mask.
- pending_mask[r] is the combinational OR over valid entries of both FIFOs plus the output register (when wr_enable=1) whose addr==r.
  - Set from the accepting edge until the edge at which the register file loads the write.
- idle = both FIFOs empty && !wr_enable.
- No special case for register 0; it is written like any other.

Optional Feature:
- Macro WRITEBACK_EMPTY_BYPASS_EN.
- Defined:
  - When the granted source's FIFO is empty, the arbiter sees its input as a virtual head.
  - The result is loaded straight into the output register at the accepting edge E, so wr_enable=1 in the cycle after E.
  - Arbitration and the pending_mask timing rules are unchanged.
- Undefined: every result passes through its FIFO, with the latency stated above.

Decomposition:
- constants_pkg gains:
  - typedef wb_entry_t, a packed struct {addr, data}.
  - WB_FIFO_DEPTH default.
  - Enum wb_src_t {WB_SRC_ALU, WB_SRC_MEM} for the round-robin pointer.
- One sub-module: wb_fifo, a parameterised synchronous FIFO of wb_entry_t.
  - Outputs: full, empty, head, and per-entry valid/addr vectors for the mask.
  - Instantiated twice.

Test Plan:
- Reset hold, then release with no traffic:
  - wr_enable=0, pending_mask=0x00, alu_ready=mem_ready=1, idle=1.
- Single ALU push, addr=3, data=0x5A at edge E:
  - pending_mask=0x08 after E.
  - wr_enable=1, wr_addr=3, wr_data=0x5A in the cycle after E+1.
  - pending_mask=0x00 and idle=1 after E+2.
- Both sources valid every cycle, ALU addr 1 and data incrementing from 0x10; mem addr 2 and data incrementing from 0x80:
  - Write port alternates ALU, mem, ALU, ...
  - Readies drop when the FIFOs hold 2; no value is lost or duplicated over 20 writes.
- mem_valid held with mem_ready=0 (FIFO filled while ALU wins):
  - mem_data is not consumed until ready=1; order preserved 0x80, 0x81, 0x82.
- Reset asserted mid-stream with 3 entries buffered:
  - Immediately wr_enable=0 and pending_mask=0.
  - After release, no stale write is ever issued.
- With WRITEBACK_EMPTY_BYPASS_EN defined, empty FIFOs, ALU push at edge E:
  - wr_enable=1 in the cycle after E.
  - Without the macro, the same push gives wr_enable=1 in the cycle after E+1.
